// File: rtl/iter_alu.sv
// iter_alu: ALU with single-cycle ADD/SUB/AND/ORR/EOR and iterative
// MUL/UDIV/UMOD, using a start/busy/done handshake and NZCV flags.
module iter_alu #(
    parameter int WIDTH  = 32,
    parameter bit DIV_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ALUControl,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       ALUFlags,
    output logic             busy,
    output logic             done
);
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_ORR  = 4'b0011;
    localparam logic [3:0] OP_EOR  = 4'b0100;
    localparam logic [3:0] OP_MUL  = 4'b0111;
    localparam logic [3:0] OP_UDIV = 4'b1000;
    localparam logic [3:0] OP_UMOD = 4'b1001;

    typedef enum logic [0:0] {IDLE, ITER} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] count;
    logic [3:0]       op;
    logic [WIDTH-1:0] op_a;     // multiplicand (MUL) / dividend shifting into quotient (DIV)
    logic [WIDTH-1:0] op_b;     // multiplier (MUL) / divisor (DIV)
    logic [WIDTH-1:0] acc;      // product accumulator (MUL) / partial remainder (DIV)

    logic             is_sub;
    logic             is_long;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] sc_result;
    logic [1:0]       sc_cv;
    logic [3:0]       sc_flags;

    logic [WIDTH:0]   rem_shift;
    logic             rem_ge;
    logic [WIDTH-1:0] acc_step, a_step, b_step, fin;

    // N and Z derived from a result; C and V are supplied by the caller.
    function automatic logic [1:0] nz_flags(input logic [WIDTH-1:0] r);
        return {r[WIDTH-1], (r == '0)};
    endfunction

    assign is_sub  = (ALUControl == OP_SUB);
    assign is_long = (ALUControl == OP_MUL) ||
                     (DIV_EN && ((ALUControl == OP_UDIV) || (ALUControl == OP_UMOD)));
    assign sum     = {1'b0, a} + {1'b0, (is_sub ? ~b : b)} + {{WIDTH{1'b0}}, is_sub};
    assign busy    = (state == ITER);

    // Single-cycle result and flags straight from the live operands.
    always_comb begin
        sc_result = '0;
        sc_cv     = 2'b00;
        case (ALUControl)
            OP_ADD, OP_SUB: begin
                sc_result = sum[WIDTH-1:0];
                sc_cv     = {sum[WIDTH],
                             ~(a[WIDTH-1] ^ b[WIDTH-1] ^ is_sub) & (a[WIDTH-1] ^ sum[WIDTH-1])};
            end
            OP_AND:  sc_result = a & b;
            OP_ORR:  sc_result = a | b;
            OP_EOR:  sc_result = a ^ b;
            default: sc_result = '0;
        endcase
        sc_flags = {nz_flags(sc_result), sc_cv};
    end

    // One radix-2 step: shift-add multiply or restoring divide.
    always_comb begin
        rem_shift = {acc, op_a[WIDTH-1]};
        rem_ge    = (rem_shift >= {1'b0, op_b});
        if (op == OP_MUL) begin
            acc_step = acc + (op_b[0] ? op_a : '0);
            a_step   = op_a << 1;
            b_step   = op_b >> 1;
            fin      = acc_step;
        end else begin
            // A zero divisor always subtracts, giving all-ones quotient and remainder = a.
            acc_step = rem_ge ? (rem_shift[WIDTH-1:0] - op_b) : rem_shift[WIDTH-1:0];
            a_step   = {op_a[WIDTH-2:0], rem_ge};
            b_step   = op_b;
            fin      = (op == OP_UMOD) ? acc_step : a_step;
        end
    end

    // Next-state logic: enter ITER for long ops, leave after the last step.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start && is_long) state_next = ITER;
            ITER:    if (count == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control and architectural outputs; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            Result   <= '0;
            ALUFlags <= 4'b0000;
            done     <= 1'b0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    if (is_long) begin
                        count <= CNT_W'(WIDTH - 1);
                    end else begin
                        Result   <= sc_result;
                        ALUFlags <= sc_flags;
                        done     <= 1'b1;
                    end
                end
            end else begin
                count <= count - 1'b1;
                if (count == '0) begin
                    Result   <= fin;
                    ALUFlags <= {nz_flags(fin), 2'b00};
                    done     <= 1'b1;
                end
            end
        end
    end

    // Iteration datapath: latch operands on accept, then step each cycle.
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            if (start) begin
                op   <= ALUControl;
                op_a <= a;
                op_b <= b;
                acc  <= '0;
            end
        end else begin
            op_a <= a_step;
            op_b <= b_step;
            acc  <= acc_step;
        end
    end
endmodule

// File: tb/tb_iter_alu.sv
// tb_iter_alu: directed vector table plus hand sequences for iter_alu.
module tb_iter_alu;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] a, b;
    logic [3:0]  ctl;
    logic [31:0] res;
    logic [3:0]  flg;
    logic        busy, done;

    logic [31:0] nd_res;
    logic [3:0]  nd_flg;
    logic        nd_busy, nd_done;

    logic        s8;
    logic [7:0]  a8, b8, r8;
    logic [3:0]  op8, f8;
    logic        busy8, done8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    iter_alu #(.WIDTH(32), .DIV_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .ALUControl(ctl),
        .Result(res), .ALUFlags(flg), .busy(busy), .done(done));

    iter_alu #(.WIDTH(32), .DIV_EN(1'b0)) dut_nd (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .ALUControl(ctl),
        .Result(nd_res), .ALUFlags(nd_flg), .busy(nd_busy), .done(nd_done));

    iter_alu #(.WIDTH(8), .DIV_EN(1'b1)) dut8 (
        .clk(clk), .reset(reset), .start(s8), .a(a8), .b(b8), .ALUControl(op8),
        .Result(r8), .ALUFlags(f8), .busy(busy8), .done(done8));

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge of cycle 1 after the start edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        ctl   = op;
        a     = x;
        b     = y;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 1;
        busy_cnt = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cnt++;
            step();
            lat++;
        end
    endtask

    initial begin
        int lat, bc, ndone;
        logic [31:0] held;

        vecs[0]  = '{4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110, 1};
        vecs[1]  = '{4'b0001, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011, 1};
        vecs[2]  = '{4'b0100, 32'hF0F0F0F0, 32'hFFFFFFFF, 32'h0F0F0F0F, 4'b0000, 1};
        vecs[3]  = '{4'b0010, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 4'b0000, 1};
        vecs[4]  = '{4'b0011, 32'h80000000, 32'h00000001, 32'h80000001, 4'b1000, 1};
        vecs[5]  = '{4'b0001, 32'h00000005, 32'h00000005, 32'h00000000, 4'b0110, 1};
        vecs[6]  = '{4'b0001, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b1000, 1};
        vecs[7]  = '{4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001, 1};
        vecs[8]  = '{4'b0101, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 4'b0100, 1};
        vecs[9]  = '{4'b0111, 32'h00010001, 32'h00010001, 32'h00020001, 4'b0000, 33};
        vecs[10] = '{4'b0111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 4'b0000, 33};
        vecs[11] = '{4'b1000, 32'd100,      32'd7,        32'd14,       4'b0000, 33};
        vecs[12] = '{4'b1001, 32'd100,      32'd7,        32'd2,        4'b0000, 33};
        vecs[13] = '{4'b1000, 32'd5,        32'd0,        32'hFFFFFFFF, 4'b1000, 33};
        vecs[14] = '{4'b1001, 32'd5,        32'd0,        32'd5,        4'b0000, 33};

        reset = 1'b1; start = 1'b0; a = '0; b = '0; ctl = '0;
        s8 = 1'b0; a8 = '0; b8 = '0; op8 = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset_result", res, 32'h0);
        check("reset_flags", {28'h0, flg}, 32'h0);
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_done", {31'h0, done}, 32'h0);
        reset = 1'b0;
        step();

        // Table-driven vectors
        for (int i = 0; i < 15; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(lat, bc);
            check($sformatf("v%0d_result", i), res, vecs[i].res);
            check($sformatf("v%0d_flags", i), {28'h0, flg}, {28'h0, vecs[i].flg});
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_busy_cycles", i), bc, vecs[i].lat - 1);
            held = res;
            step();
            check($sformatf("v%0d_done_drop", i), {31'h0, done}, 32'h0);
            step();
            check($sformatf("v%0d_hold", i), res, held);
        end

        // Back-to-back: SUB then EOR issued in the SUB done cycle
        issue(4'b0001, 32'h80000000, 32'h00000001);
        wait_done(lat, bc);
        check("b2b_sub_result", res, 32'h7FFFFFFF);
        check("b2b_sub_flags", {28'h0, flg}, 32'h3);
        issue(4'b0100, 32'hF0F0F0F0, 32'hFFFFFFFF);
        wait_done(lat, bc);
        check("b2b_eor_latency", lat, 1);
        check("b2b_eor_result", res, 32'h0F0F0F0F);
        check("b2b_eor_flags", {28'h0, flg}, 32'h0);
        step();

        // Start during MUL must be ignored
        issue(4'b0111, 32'h00010001, 32'h00010001);
        repeat (5) step();
        start = 1'b1; ctl = 4'b0000; a = 32'd3; b = 32'd5;
        step();
        start = 1'b0;
        wait_done(lat, bc);
        check("ignore_latency", lat + 6, 33);
        check("ignore_result", res, 32'h00020001);
        step();

        // Reset at iteration 10 of a MUL aborts with no done pulse
        issue(4'b0111, 32'h00010001, 32'h00010001);
        repeat (9) step();
        reset = 1'b1;
        step();
        check("abort_result", res, 32'h0);
        check("abort_flags", {28'h0, flg}, 32'h0);
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_done", {31'h0, done}, 32'h0);
        reset = 1'b0;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) ndone++;
            step();
        end
        check("abort_no_done", ndone, 0);
        issue(4'b0000, 32'd2, 32'd3);
        wait_done(lat, bc);
        check("post_abort_latency", lat, 1);
        check("post_abort_result", res, 32'd5);
        step();

        // DIV_EN=0: UDIV is an unknown opcode
        issue(4'b1000, 32'd100, 32'd7);
        check("nodiv_done", {31'h0, nd_done}, 32'h1);
        check("nodiv_busy", {31'h0, nd_busy}, 32'h0);
        check("nodiv_result", nd_res, 32'h0);
        check("nodiv_flags", {28'h0, nd_flg}, 32'h4);
        wait_done(lat, bc);
        check("div_result_alongside", res, 32'd14);
        step();

        // WIDTH=8 MUL overflow to zero
        s8 = 1'b1; op8 = 4'b0111; a8 = 8'h10; b8 = 8'h10;
        step();
        s8 = 1'b0;
        lat = 1;
        bc = 0;
        while (!done8 && lat < 50) begin
            if (busy8) bc++;
            step();
            lat++;
        end
        check("w8_latency", lat, 9);
        check("w8_busy_cycles", bc, 8);
        check("w8_result", {24'h0, r8}, 32'h0);
        check("w8_flags", {28'h0, f8}, 32'h4);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
